gol_field_sequencer: RTL and testbench
======================================

Name: gol_field_sequencer

Overview:
- Central sequencer for the Game of Life datapath. It replaces the ad-hoc pause/load glue with one FSM.
- It arbitrates between the next-field iterator and the config loader, and supports NUM_CFGS config ROMs.
- It owns the ping-pong field selection, with the swap synchronised to the VGA frame start.
- It adds a programmable generation period, single-step mode and a generation counter.

Parameters:
- NUM_CFGS, 2, number of selectable config ROMs (>=1).
- GEN_PERIOD, 3072000, clk cycles between generation starts while running (>=2).
- GEN_CNT_W, 16, generation counter width.
- START_PAUSED, 1, paused state after reset.

Ports:
- clk  in  1  system clock (VGA pixel clock).
- rst  in  1  synchronous active-high reset.
- i_cmd_toggle_pause  in  1  one-cycle pulse; toggles pause.
- i_cmd_step  in  1  one-cycle pulse; runs one generation when paused.
- i_cmd_load_cfg  in  NUM_CFGS  one-cycle pulses; bit k requests config k.
- i_frame_start  in  1  one-cycle pulse at first blanking line of a VGA frame.
- i_nfi_busy  in  1  iterator busy.
- i_fcl_busy  in  1  loader busy.
- o_nfi_go  out  1  one-cycle iterator start pulse.
- o_fcl_go  out  1  one-cycle loader start pulse.
- o_cfg_sel  out  $clog2(NUM_CFGS) (min 1)  config index driven to the ROM mux; stable during load.
- o_read_field  out  field_t  field displayed and read by the iterator; the other field is written.
- o_paused  out  1  current pause state.
- o_busy  out  1  high in any state except IDLE.
- o_gen_cnt  out  GEN_CNT_W  generations since last load; wraps.

Behaviour:
- Reset (sync, rst=1):
  - State IDLE; o_paused=START_PAUSED.
  - o_read_field=FIELD_A; o_gen_cnt=0; o_cfg_sel=0.
  - Both go outputs 0; pending load cleared; period timer 0.
- States: IDLE, LOAD_GO, LOADING, SIM_GO, SIMULATING, SWAP_WAIT.
- Load request latch:
  - Any i_cmd_load_cfg bit set latches a pending request, in any state.
  - Simultaneous bits: lowest index wins. A later request overwrites an earlier unserved one.
- IDLE:
  - Pending load has priority: -> LOAD_GO.
  - Else, if not paused, the timer increments. At GEN_PERIOD-1 the timer clears -> SIM_GO.
  - Else, if paused and i_cmd_step=1 -> SIM_GO. i_cmd_step is ignored when not paused or not in IDLE.
- LOAD_GO:
  - o_fcl_go=1 for exactly this cycle; o_cfg_sel=latched index; pending cleared -> LOADING.
- LOADING:
  - Waits until i_fcl_busy has been sampled 1, then 0.
  - On exit: o_gen_cnt=0, timer=0 -> IDLE.
  - The loader writes into o_read_field; o_read_field is unchanged.
- SIM_GO:
  - o_nfi_go=1 for exactly this cycle -> SIMULATING.
- SIMULATING:
  - Same busy-seen-then-low rule as LOADING -> SWAP_WAIT.
- SWAP_WAIT:
  - Waits for i_frame_start; if it is 1 on the entry cycle, the swap happens that cycle.
  - On swap: o_read_field toggles, o_gen_cnt+1 (wraps) -> IDLE.
- Pause:
  - i_cmd_toggle_pause toggles o_paused in any state. It affects only the IDLE timer; an in-flight generation completes.
  - The timer holds its value while paused.
- Go handshake:
  - Go pulses are never issued while the other engine's busy is 1.
  - A busy input high on entry to IDLE is a protocol error; no recovery beyond rst.
- Reset mid-operation returns to reset values next cycle; partially written field contents are undefined.

Optional Feature:
- Macro GOL_SEQ_VBLANK_SWAP_EN.
- Defined: SWAP_WAIT behaves as specified.
- Undefined: SWAP_WAIT is bypassed; the swap occurs on the SIMULATING exit cycle and i_frame_start is unused. Tearing is accepted.

Decomposition:
- Package defs_gol:
  - field_t (FIELD_A=0, FIELD_B=1).
  - seq_state_t enum.
  - Constants NEIGHBOURS_CNT and the default GEN_PERIOD.
- Sub-module gen_rate_timer:
  - Counter with enable, clear and a terminal-count pulse.
  - Parametrised by PERIOD.

Test Plan:
1. Reset with START_PAUSED=1, GEN_PERIOD=8, no commands for 100 cycles -> no o_nfi_go; o_read_field=FIELD_A; o_gen_cnt=0.
2. Toggle pause, iterator model busy 5 cycles -> o_nfi_go at cycle 8 after unpause. Swap on next i_frame_start -> o_read_field=FIELD_B, o_gen_cnt=1. Repeats every 8+5+frame-wait cycles.
3. i_cmd_load_cfg=2'b11 while SIMULATING -> load deferred until after swap. o_fcl_go once with o_cfg_sel=0; o_gen_cnt=0 after i_fcl_busy falls.
4. Paused, i_cmd_step three times (each after returning to IDLE) -> exactly 3 o_nfi_go pulses and o_gen_cnt=3. Step while running -> no extra pulse.
5. Load request and timer terminal count in the same IDLE cycle -> LOAD_GO wins. SIM_GO follows a full period after load completes.
6. rst asserted in SWAP_WAIT -> next cycle: IDLE, FIELD_A, o_gen_cnt=0, o_paused=START_PAUSED. With the macro undefined, the swap happens without i_frame_start.

Source files
------------

// File: rtl/gol_field_sequencer_pkg.sv
// Shared definitions for the Game of Life sequencer slice.
//   field_t     : ping-pong field identifier (FIELD_A / FIELD_B)
//   seq_state_t : sequencer FSM state encoding
//   NEIGHBOURS_CNT, DEFAULT_GEN_PERIOD : datapath-wide constants
//   sel_width() : width of a config index, never below one bit
package defs_gol;

    typedef enum logic {
        FIELD_A = 1'b0,
        FIELD_B = 1'b1
    } field_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD_GO    = 3'd1,
        ST_LOADING    = 3'd2,
        ST_SIM_GO     = 3'd3,
        ST_SIMULATING = 3'd4,
        ST_SWAP_WAIT  = 3'd5
    } seq_state_t;

    localparam int NEIGHBOURS_CNT     = 8;
    localparam int DEFAULT_GEN_PERIOD = 3072000;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gol_field_sequencer_if.sv
// Engine handshake bundle between the sequencer and the two datapath engines
// (next-field iterator "nfi" and config loader "fcl").
//   nfi_go   : sequencer -> iterator, one-cycle start pulse   (o_nfi_go)
//   nfi_busy : iterator  -> sequencer, iterator busy          (i_nfi_busy)
//   fcl_go   : sequencer -> loader, one-cycle start pulse     (o_fcl_go)
//   fcl_busy : loader    -> sequencer, loader busy            (i_fcl_busy)
//   cfg_sel  : sequencer -> ROM mux, config index             (o_cfg_sel)
// master = sequencer side, slave = engine side.
interface gol_field_sequencer_if #(
    parameter int CFG_SEL_W = 1
);

    logic                 nfi_go;
    logic                 nfi_busy;
    logic                 fcl_go;
    logic                 fcl_busy;
    logic [CFG_SEL_W-1:0] cfg_sel;

    modport master (
        output nfi_go,
        output fcl_go,
        output cfg_sel,
        input  nfi_busy,
        input  fcl_busy
    );

    modport slave (
        input  nfi_go,
        input  fcl_go,
        input  cfg_sel,
        output nfi_busy,
        output fcl_busy
    );

endinterface

// File: rtl/gol_field_sequencer_gen_rate_timer.sv
// Generation-rate timer: counts enabled cycles and pulses tc on the cycle the
// count reaches PERIOD-1, clearing itself on that same edge.
//   clk, rst : clock, synchronous active-high reset
//   en       : count this cycle (count holds when low)
//   clr      : force count to zero (wins over en)
//   tc       : terminal count, combinational, only while en is high
module gen_rate_timer #(
    parameter int PERIOD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int                CNT_W = $clog2(PERIOD);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] count_q;

    assign tc = en && (count_q == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else if (tc) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/gol_field_sequencer.sv
// Central Game of Life sequencer: one FSM arbitrating between the next-field
// iterator and the config loader, owning the ping-pong field selection, the
// generation period timer, single-step and the generation counter.
//   clk, rst           : pixel clock, synchronous active-high reset
//   i_cmd_toggle_pause : pulse, toggles pause (any state)
//   i_cmd_step         : pulse, one generation when paused and idle
//   i_cmd_load_cfg     : pulses, bit k requests config k (lowest bit wins)
//   i_frame_start      : pulse at first blanking line of a VGA frame
//   eng (master)       : iterator/loader go+busy handshake and cfg_sel
//   o_read_field       : field displayed and read by the iterator
//   o_paused, o_busy   : pause state, FSM not in IDLE
//   o_gen_cnt          : generations since last load, wraps
// Build option GOL_SEQ_VBLANK_SWAP_EN: when defined the field swap waits for
// i_frame_start; otherwise it happens as the iterator finishes (tearing
// accepted) and i_frame_start is ignored.
module gol_field_sequencer
    import defs_gol::*;
#(
    parameter int NUM_CFGS     = 2,
    parameter int GEN_PERIOD   = DEFAULT_GEN_PERIOD,
    parameter int GEN_CNT_W    = 16,
    parameter bit START_PAUSED = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_cmd_toggle_pause,
    input  logic                 i_cmd_step,
    input  logic [NUM_CFGS-1:0]  i_cmd_load_cfg,
    input  logic                 i_frame_start,
    gol_field_sequencer_if.master eng,
    output field_t               o_read_field,
    output logic                 o_paused,
    output logic                 o_busy,
    output logic [GEN_CNT_W-1:0] o_gen_cnt
);

    localparam int CFG_SEL_W = sel_width(NUM_CFGS);

    localparam logic [2:0] S_IDLE       = ST_IDLE;
    localparam logic [2:0] S_LOAD_GO    = ST_LOAD_GO;
    localparam logic [2:0] S_LOADING    = ST_LOADING;
    localparam logic [2:0] S_SIM_GO     = ST_SIM_GO;
    localparam logic [2:0] S_SIMULATING = ST_SIMULATING;
    localparam logic [2:0] S_SWAP_WAIT  = ST_SWAP_WAIT;

    function automatic logic [CFG_SEL_W-1:0] lowest_set(input logic [NUM_CFGS-1:0] req);
        logic [CFG_SEL_W-1:0] idx;
        idx = '0;
        for (int k = NUM_CFGS - 1; k >= 0; k--) begin
            if (req[k]) idx = CFG_SEL_W'(k);
        end
        return idx;
    endfunction

    logic [2:0]           state_q, state_d;
    logic                 paused_q;
    field_t               read_field_q;
    logic [GEN_CNT_W-1:0] gen_cnt_q;
    logic [CFG_SEL_W-1:0] cfg_sel_q;
    logic                 load_pend_q;
    logic [CFG_SEL_W-1:0] load_idx_q;
    logic                 busy_seen_q;

    logic                 load_cmd_any;
    logic                 load_req_any;
    logic [CFG_SEL_W-1:0] load_idx_now;
    logic                 engines_idle;
    logic                 tmr_en, tmr_clr, tmr_tc;
    logic                 load_done, swap_now;

    // A request arriving in the very cycle IDLE decides still counts, so a
    // load pulse coinciding with the timer terminal count wins over SIM_GO.
    assign load_cmd_any = |i_cmd_load_cfg;
    assign load_req_any = load_pend_q || load_cmd_any;
    assign load_idx_now = load_cmd_any ? lowest_set(i_cmd_load_cfg) : load_idx_q;

    // No go pulse may be issued while either engine still reports busy.
    assign engines_idle = !eng.nfi_busy && !eng.fcl_busy;

    gen_rate_timer #(
        .PERIOD (GEN_PERIOD)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .en  (tmr_en),
        .clr (tmr_clr),
        .tc  (tmr_tc)
    );

    always_comb begin
        state_d   = state_q;
        tmr_en    = 1'b0;
        tmr_clr   = 1'b0;
        load_done = 1'b0;
        swap_now  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (engines_idle) begin
                    if (load_req_any) begin
                        state_d = S_LOAD_GO;
                    end else if (!paused_q) begin
                        tmr_en = 1'b1;
                        if (tmr_tc) state_d = S_SIM_GO;
                    end else if (i_cmd_step) begin
                        state_d = S_SIM_GO;
                    end
                end
            end
            S_LOAD_GO: state_d = S_LOADING;
            S_LOADING: begin
                if (busy_seen_q && !eng.fcl_busy) begin
                    load_done = 1'b1;
                    tmr_clr   = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_SIM_GO: state_d = S_SIMULATING;
            S_SIMULATING: begin
                if (busy_seen_q && !eng.nfi_busy) begin
`ifdef GOL_SEQ_VBLANK_SWAP_EN
                    state_d = S_SWAP_WAIT;
`else
                    swap_now = 1'b1;
                    state_d  = S_IDLE;
`endif
                end
            end
            S_SWAP_WAIT: begin
`ifdef GOL_SEQ_VBLANK_SWAP_EN
                if (i_frame_start) begin
                    swap_now = 1'b1;
                    state_d  = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifndef GOL_SEQ_VBLANK_SWAP_EN
    logic unused_frame_start;
    assign unused_frame_start = i_frame_start;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            paused_q     <= START_PAUSED;
            read_field_q <= FIELD_A;
            gen_cnt_q    <= '0;
            cfg_sel_q    <= '0;
            load_pend_q  <= 1'b0;
            load_idx_q   <= '0;
            busy_seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;

            if (i_cmd_toggle_pause) paused_q <= !paused_q;

            // A fresh request always wins over clearing the served one.
            if (load_cmd_any) begin
                load_pend_q <= 1'b1;
                load_idx_q  <= lowest_set(i_cmd_load_cfg);
            end else if (state_q == S_LOAD_GO) begin
                load_pend_q <= 1'b0;
            end

            // cfg_sel is frozen from LOAD_GO until the next load.
            if (state_q == S_IDLE && state_d == S_LOAD_GO) cfg_sel_q <= load_idx_now;

            // Completion requires busy to have been seen high, so an engine
            // that is slow to raise busy is not mistaken for one that is done.
            if (state_q == S_LOAD_GO || state_q == S_SIM_GO) begin
                busy_seen_q <= 1'b0;
            end else if (state_q == S_LOADING && eng.fcl_busy) begin
                busy_seen_q <= 1'b1;
            end else if (state_q == S_SIMULATING && eng.nfi_busy) begin
                busy_seen_q <= 1'b1;
            end

            if (load_done) begin
                gen_cnt_q <= '0;
            end else if (swap_now) begin
                read_field_q <= (read_field_q == FIELD_A) ? FIELD_B : FIELD_A;
                gen_cnt_q    <= gen_cnt_q + 1'b1;
            end
        end
    end

    assign eng.nfi_go  = (state_q == S_SIM_GO);
    assign eng.fcl_go  = (state_q == S_LOAD_GO);
    assign eng.cfg_sel = cfg_sel_q;

    assign o_read_field = read_field_q;
    assign o_paused     = paused_q;
    assign o_busy       = (state_q != S_IDLE);
    assign o_gen_cnt    = gen_cnt_q;

endmodule

// File: tb/tb_gol_field_sequencer.sv
// Directed bench for gol_field_sequencer (NUM_CFGS=2, GEN_PERIOD=8,
// START_PAUSED=1) with behavioural iterator (busy 5 cycles) and loader
// (busy 4 cycles) models and a 20-cycle frame-start generator.
module tb_gol_field_sequencer;
    import defs_gol::*;

    localparam int W_NFI  = 0;
    localparam int W_FCL  = 1;
    localparam int W_IDLE = 2;

    typedef struct {
        bit         toggle;
        bit         step;
        logic [1:0] load;
        int         cycles;
        int         e_paused;
        int         e_field;
        int         e_gen;
        int         e_nfi;
        int         e_fcl;
        int         e_cfg;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        toggle;
    logic        step;
    logic [1:0]  load;
    logic        frame_start;
    field_t      read_field;
    logic        paused;
    logic        busy;
    logic [15:0] gen_cnt;

    int  nfi_cnt, fcl_cnt;
    int  nfi_left, fcl_left;
    int  fcnt;
    bit  frame_en;
    int  n_checks, n_pass;
    int  cyc;
    vec_t tbl [8];

    gol_field_sequencer_if #(.CFG_SEL_W(1)) eng ();

    gol_field_sequencer #(
        .NUM_CFGS     (2),
        .GEN_PERIOD   (8),
        .GEN_CNT_W    (16),
        .START_PAUSED (1'b1)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .i_cmd_toggle_pause (toggle),
        .i_cmd_step         (step),
        .i_cmd_load_cfg     (load),
        .i_frame_start      (frame_start),
        .eng                (eng),
        .o_read_field       (read_field),
        .o_paused           (paused),
        .o_busy             (busy),
        .o_gen_cnt          (gen_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Engine models: busy rises the cycle after go.
    always @(posedge clk) begin
        if (rst) begin
            nfi_left <= 0;
            fcl_left <= 0;
        end else begin
            if (eng.nfi_go) nfi_left <= 5;
            else if (nfi_left != 0) nfi_left <= nfi_left - 1;
            if (eng.fcl_go) fcl_left <= 4;
            else if (fcl_left != 0) fcl_left <= fcl_left - 1;
        end
    end
    assign eng.nfi_busy = (nfi_left != 0);
    assign eng.fcl_busy = (fcl_left != 0);

    always @(posedge clk) begin
        fcnt        <= (fcnt == 19) ? 0 : fcnt + 1;
        frame_start <= frame_en && (fcnt == 19);
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (eng.nfi_go) nfi_cnt++;
            if (eng.fcl_go) fcl_cnt++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Called at a negedge; leaves the inputs asserted for exactly one edge.
    task automatic pulse(input bit t, input bit s, input logic [1:0] l);
        toggle = t;
        step   = s;
        load   = l;
        @(negedge clk);
        toggle = 1'b0;
        step   = 1'b0;
        load   = 2'b00;
    endtask

    task automatic wait_for(input string name, input int what, input int limit, output int c);
        bit hit;
        c   = 0;
        hit = 1'b0;
        while (!hit && c < limit) begin
            @(posedge clk);
            c++;
            @(negedge clk);
            case (what)
                W_NFI:   hit = eng.nfi_go;
                W_FCL:   hit = eng.fcl_go;
                default: hit = !busy;
            endcase
        end
        if (!hit) begin
            n_checks++;
            $display("FAIL %s: timeout after %0d cycles, event not seen", name, limit);
            c = -1;
        end
    endtask

    initial begin
        n_checks = 0; n_pass = 0; nfi_cnt = 0; fcl_cnt = 0; fcnt = 0;
        frame_en = 1'b1;
        toggle = 1'b0; step = 1'b0; load = 2'b00; frame_start = 1'b0;
        rst = 1'b1;

        //           tog step load  cyc paus fld gen nfi fcl cfg
        tbl[0] = '{1'b0, 1'b1, 2'b00, 40, 1, 1, 1, 1, 0, 0};
        tbl[1] = '{1'b0, 1'b1, 2'b00, 40, 1, 0, 2, 2, 0, 0};
        tbl[2] = '{1'b0, 1'b1, 2'b00, 40, 1, 1, 3, 3, 0, 0};
        tbl[3] = '{1'b1, 1'b0, 2'b00,  3, 0, 1, 3, 3, 0, 0};
        tbl[4] = '{1'b1, 1'b0, 2'b00,  3, 1, 1, 3, 3, 0, 0};
        tbl[5] = '{1'b0, 1'b0, 2'b10, 30, 1, 1, 0, 3, 1, 1};
        tbl[6] = '{1'b0, 1'b0, 2'b11, 30, 1, 1, 0, 3, 2, 0};
        tbl[7] = '{1'b0, 1'b1, 2'b00, 40, 1, 0, 1, 4, 2, 0};

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state, then 100 idle cycles while paused.
        check("rst_paused", int'(paused), 1);
        check("rst_field", int'(read_field), 0);
        check("rst_gen", int'(gen_cnt), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_nfi_go", int'(eng.nfi_go), 0);
        check("rst_fcl_go", int'(eng.fcl_go), 0);
        check("rst_cfg_sel", int'(eng.cfg_sel), 0);
        repeat (100) @(negedge clk);
        check("paused_no_go", nfi_cnt, 0);
        check("paused_field", int'(read_field), 0);
        check("paused_gen", int'(gen_cnt), 0);

        for (int i = 0; i < 8; i++) begin
            pulse(tbl[i].toggle, tbl[i].step, tbl[i].load);
            repeat (tbl[i].cycles) @(negedge clk);
            check($sformatf("row%0d_paused", i), int'(paused), tbl[i].e_paused);
            check($sformatf("row%0d_field", i), int'(read_field), tbl[i].e_field);
            check($sformatf("row%0d_gen", i), int'(gen_cnt), tbl[i].e_gen);
            check($sformatf("row%0d_nfi", i), nfi_cnt, tbl[i].e_nfi);
            check($sformatf("row%0d_fcl", i), fcl_cnt, tbl[i].e_fcl);
            check($sformatf("row%0d_cfg", i), int'(eng.cfg_sel), tbl[i].e_cfg);
        end

        // Unpause: eight idle cycles of timer, then go.
        pulse(1'b1, 1'b0, 2'b00);
        wait_for("unpause_go", W_NFI, 20, cyc);
        check("unpause_latency", cyc, 8);
        wait_for("gen2_done", W_IDLE, 60, cyc);
        check("gen2_cnt", int'(gen_cnt), 2);
        check("gen2_field", int'(read_field), 1);

        // Step while running is ignored; the pulse uses one of the 8 idle cycles.
        pulse(1'b0, 1'b1, 2'b00);
        wait_for("run_step_go", W_NFI, 20, cyc);
        check("run_step_latency", cyc, 7);
        wait_for("gen3_done", W_IDLE, 60, cyc);
        check("gen3_cnt", int'(gen_cnt), 3);
        check("gen3_field", int'(read_field), 0);

        // Load 2'b11 during SIMULATING plus pause: deferred until after swap.
        wait_for("c_go", W_NFI, 20, cyc);
        @(negedge clk);
        pulse(1'b1, 1'b0, 2'b11);
        wait_for("c_fcl_go", W_FCL, 60, cyc);
        check("c_gen_at_load", int'(gen_cnt), 4);
        check("c_field_at_load", int'(read_field), 1);
        check("c_cfg_sel", int'(eng.cfg_sel), 0);
        check("c_nfi_cnt", nfi_cnt, 7);
        wait_for("c_load_done", W_IDLE, 30, cyc);
        check("c_gen_cleared", int'(gen_cnt), 0);
        check("c_field_kept", int'(read_field), 1);
        check("c_paused", int'(paused), 1);
        check("c_fcl_cnt", fcl_cnt, 3);
        repeat (30) @(negedge clk);
        check("c_no_go_paused", nfi_cnt, 7);

        // Load request on the timer terminal-count cycle: load wins.
        pulse(1'b1, 1'b0, 2'b00);
        repeat (7) @(negedge clk);
        check("t5_no_early_go", int'(eng.nfi_go), 0);
        check("t5_idle", int'(busy), 0);
        pulse(1'b0, 1'b0, 2'b10);
        check("t5_fcl_go", int'(eng.fcl_go), 1);
        check("t5_nfi_go", int'(eng.nfi_go), 0);
        check("t5_cfg_sel", int'(eng.cfg_sel), 1);
        wait_for("t5_load_done", W_IDLE, 30, cyc);
        check("t5_gen", int'(gen_cnt), 0);
        wait_for("t5_go", W_NFI, 20, cyc);
        check("t5_full_period", cyc, 8);
        pulse(1'b1, 1'b0, 2'b00);
        wait_for("t5_gen_done", W_IDLE, 60, cyc);
        check("t5_gen1", int'(gen_cnt), 1);
        check("t5_field", int'(read_field), 0);
        check("t5_paused", int'(paused), 1);
        check("t5_nfi_cnt", nfi_cnt, 8);

        // Reset during an in-flight generation.
        pulse(1'b0, 1'b1, 2'b00);
        check("t6_step_go", int'(eng.nfi_go), 1);
        wait_for("t6_gen_done", W_IDLE, 60, cyc);
        check("t6_gen2", int'(gen_cnt), 2);
        frame_en = 1'b0;
        pulse(1'b1, 1'b1, 2'b00);
        check("t6_go2", int'(eng.nfi_go), 1);
`ifdef GOL_SEQ_VBLANK_SWAP_EN
        repeat (10) @(negedge clk);
`else
        repeat (3) @(negedge clk);
`endif
        check("t6_busy_before_rst", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_field", int'(read_field), 0);
        check("t6_rst_gen", int'(gen_cnt), 0);
        check("t6_rst_paused", int'(paused), 1);
        check("t6_rst_cfg", int'(eng.cfg_sel), 0);
`ifndef GOL_SEQ_VBLANK_SWAP_EN
        // Without vblank sync the swap needs no frame start.
        pulse(1'b0, 1'b1, 2'b00);
        check("t6_nosync_go", int'(eng.nfi_go), 1);
        wait_for("t6_nosync_done", W_IDLE, 40, cyc);
        check("t6_nosync_field", int'(read_field), 1);
        check("t6_nosync_gen", int'(gen_cnt), 1);
`endif
        frame_en = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
